hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_pkg.sv | 15 +
 rtl/hazard_cmp.sv | 25 ++
 rtl/hazard_ctrl.sv | 137 +++++++++++++
 tb/tb_hazard_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared encodings for the pipeline hazard controller
package hazard_ctrl_pkg;

  localparam logic [1:0] RD_SRC_ALU = 2'd0;
  localparam logic [1:0] RD_SRC_MEM = 2'd1;
  localparam logic [1:0] RD_SRC_PC4 = 2'd2;

  localparam int MC_TIMEOUT_DEF = 64;

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_MC_WAIT = 1'b1
  } hz_state_t;

endpackage

// File: rtl/hazard_cmp.sv
// rtl/hazard_cmp.sv - load-use detect between the EX load and the ID reader
module hazard_cmp
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] ID_rs1_addr_i,
  input  logic [4:0] ID_rs2_addr_i,
  input  logic       ID_rs1_used_i,
  input  logic       ID_rs2_used_i,
  input  logic [4:0] EX_rd_addr_i,
  input  logic       EX_rd_wr_en_i,
  input  logic [1:0] EX_rd_src_i,
  output logic       load_use_o
);

  logic w_ex_load;
  logic w_rs1_hit;
  logic w_rs2_hit;

  // x0 is never a real dependency
  assign w_ex_load  = EX_rd_wr_en_i & (EX_rd_src_i == RD_SRC_MEM) & (EX_rd_addr_i != 5'd0);
  assign w_rs1_hit  = ID_rs1_used_i & (ID_rs1_addr_i == EX_rd_addr_i);
  assign w_rs2_hit  = ID_rs2_used_i & (ID_rs2_addr_i == EX_rd_addr_i);
  assign load_use_o = w_ex_load & (w_rs1_hit | w_rs2_hit);

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall/flush/bubble control with multi-cycle unit handshake
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MC_TIMEOUT = MC_TIMEOUT_DEF,
  parameter int CNT_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       ID_rs1_addr_i,
  input  logic [4:0]       ID_rs2_addr_i,
  input  logic             ID_rs1_used_i,
  input  logic             ID_rs2_used_i,
  input  logic             ID_mc_req_i,
  input  logic [4:0]       EX_rd_addr_i,
  input  logic             EX_rd_wr_en_i,
  input  logic [1:0]       EX_rd_src_i,
  input  logic             EX_branch_taken_i,
  input  logic             mc_done_i,
  output logic             stall_o,
  output logic             flush_o,
  output logic             bubble_o,
  output logic             mc_start_o,
  output logic             mc_abort_o,
  output logic             mc_busy_o,
  output logic             err_timeout_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam int TMR_W = (MC_TIMEOUT > 1) ? $clog2(MC_TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MC_TIMEOUT - 1);

  hz_state_t        r_state;
  logic [TMR_W-1:0] r_timer;
  logic             r_err;
  logic [CNT_W-1:0] r_cnt;

  logic w_load_use;
  logic w_stall;
  logic w_flush;
  logic w_bubble;
  logic w_start;
  logic w_abort;
  logic w_busy;

  hazard_cmp u_cmp (
    .ID_rs1_addr_i (ID_rs1_addr_i),
    .ID_rs2_addr_i (ID_rs2_addr_i),
    .ID_rs1_used_i (ID_rs1_used_i),
    .ID_rs2_used_i (ID_rs2_used_i),
    .EX_rd_addr_i  (EX_rd_addr_i),
    .EX_rd_wr_en_i (EX_rd_wr_en_i),
    .EX_rd_src_i   (EX_rd_src_i),
    .load_use_o    (w_load_use)
  );

  always_comb begin
    w_stall  = 1'b0;
    w_flush  = 1'b0;
    w_bubble = 1'b0;
    w_start  = 1'b0;
    w_abort  = 1'b0;
    w_busy   = 1'b0;
    if (!rst_i) begin
      case (r_state)
        ST_RUN: begin
          if (EX_branch_taken_i) begin
            w_flush  = 1'b1;
            w_bubble = 1'b1;
          end else if (w_load_use) begin
            w_stall  = 1'b1;
            w_bubble = 1'b1;
          end else if (ID_mc_req_i) begin
            w_start  = 1'b1;
            w_stall  = 1'b1;
            w_bubble = 1'b1;
          end
        end
        ST_MC_WAIT: begin
          w_busy = 1'b1;
          // on done the held instruction advances carrying the result
          if (!mc_done_i) begin
            if (r_timer == TMR_LAST) begin
              w_abort  = 1'b1;
              w_bubble = 1'b1;
            end else begin
              w_stall  = 1'b1;
              w_bubble = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_RUN;
      r_timer <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      if (w_stall && (r_cnt != '1)) begin
        r_cnt <= r_cnt + 1'b1;
      end
      case (r_state)
        ST_RUN: begin
          if (w_start) begin
            r_state <= ST_MC_WAIT;
            r_timer <= '0;
          end
        end
        ST_MC_WAIT: begin
          r_timer <= r_timer + 1'b1;
          if (mc_done_i) begin
            r_state <= ST_RUN;
          end else if (w_abort) begin
            r_state <= ST_RUN;
            r_err   <= 1'b1;
          end
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  assign stall_o       = w_stall;
  assign flush_o       = w_flush;
  assign bubble_o      = w_bubble;
  assign mc_start_o    = w_start;
  assign mc_abort_o    = w_abort;
  assign mc_busy_o     = w_busy;
  assign err_timeout_o = r_err;
  assign stall_cnt_o   = r_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  localparam int TO   = 64;
  localparam int CW   = 4;
  localparam int CMAX = 15;

  logic          clk;
  logic          rst;
  logic [4:0]    id_rs1, id_rs2, ex_rd;
  logic          id_rs1_u, id_rs2_u, id_mc, ex_wr, br, done;
  logic [1:0]    ex_src;
  logic          stall, flush, bubble, start, abort, busy, err;
  logic [CW-1:0] cnt;

  hazard_ctrl #(.MC_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .ID_rs1_addr_i     (id_rs1),
    .ID_rs2_addr_i     (id_rs2),
    .ID_rs1_used_i     (id_rs1_u),
    .ID_rs2_used_i     (id_rs2_u),
    .ID_mc_req_i       (id_mc),
    .EX_rd_addr_i      (ex_rd),
    .EX_rd_wr_en_i     (ex_wr),
    .EX_rd_src_i       (ex_src),
    .EX_branch_taken_i (br),
    .mc_done_i         (done),
    .stall_o           (stall),
    .flush_o           (flush),
    .bubble_o          (bubble),
    .mc_start_o        (start),
    .mc_abort_o        (abort),
    .mc_busy_o         (busy),
    .err_timeout_o     (err),
    .stall_cnt_o       (cnt)
  );

  typedef struct packed {
    logic          stall;
    logic          flush;
    logic          bubble;
    logic          start;
    logic          abort;
    logic          busy;
    logic          err;
    logic [CW-1:0] cnt;
  } obs_t;

  typedef struct {
    logic [4:0] rd;
    logic       wr;
    logic [1:0] src;
    logic [4:0] rs1;
    logic       rs1u;
    logic [4:0] rs2;
    logic       rs2u;
    int         exp_stalls;
  } lu_case_t;

  obs_t sb[$];
  int   n_checks = 0;
  int   n_errs   = 0;
  bit   m_wait;
  int   m_tmr;
  bit   m_err;
  int   m_cnt;
  int   n_stall, n_start, n_abort, n_flush, abort_at, rel;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic obs_t model_comb();
    obs_t e;
    bit   hit;
    e     = '0;
    e.err = m_err;
    e.cnt = CW'(m_cnt);
    hit = ex_wr && ex_src == RD_SRC_MEM && ex_rd != 0 &&
          ((id_rs1_u && id_rs1 == ex_rd) || (id_rs2_u && id_rs2 == ex_rd));
    if (!rst) begin
      if (m_wait) begin
        e.busy = 1'b1;
        if (!done && m_tmr == TO - 1) begin
          e.abort  = 1'b1;
          e.bubble = 1'b1;
        end else if (!done) begin
          e.stall  = 1'b1;
          e.bubble = 1'b1;
        end
      end else if (br) begin
        e.flush  = 1'b1;
        e.bubble = 1'b1;
      end else if (hit || id_mc) begin
        e.stall  = 1'b1;
        e.bubble = 1'b1;
        e.start  = !hit;
      end
    end
    return e;
  endfunction

  task automatic model_step(input obs_t x);
    if (rst) begin
      m_wait = 0; m_tmr = 0; m_err = 0; m_cnt = 0;
    end else begin
      if (x.stall && m_cnt < CMAX) m_cnt++;
      if (!m_wait) begin
        if (x.start) begin
          m_wait = 1;
          m_tmr  = 0;
        end
      end else if (x.abort) begin
        m_err  = 1;
        m_wait = 0;
      end else if (done) begin
        m_wait = 0;
      end else begin
        m_tmr++;
      end
    end
  endtask

  task automatic do_cycle();
    obs_t e, a, x;
    e = model_comb();
    sb.push_back(e);
    @(negedge clk);
    a.stall = stall; a.flush = flush; a.bubble = bubble; a.start = start;
    a.abort = abort; a.busy = busy;  a.err = err;       a.cnt = cnt;
    x = sb.pop_front();
    check_eq("stall_o", a.stall, x.stall);
    check_eq("flush_o", a.flush, x.flush);
    check_eq("bubble_o", a.bubble, x.bubble);
    check_eq("mc_start_o", a.start, x.start);
    check_eq("mc_abort_o", a.abort, x.abort);
    check_eq("mc_busy_o", a.busy, x.busy);
    check_eq("err_timeout_o", a.err, x.err);
    check_eq("stall_cnt_o", a.cnt, x.cnt);
    n_stall += a.stall; n_start += a.start; n_flush += a.flush;
    if (a.abort) begin
      n_abort++;
      abort_at = rel;
    end
    @(posedge clk);
    model_step(x);
    #1;
    rel++;
  endtask

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; id_rs1_u = 0; id_rs2_u = 0; id_mc = 0;
    ex_rd = 0; ex_wr = 0; ex_src = RD_SRC_ALU; br = 0; done = 0;
  endtask

  task automatic clr();
    n_stall = 0; n_start = 0; n_abort = 0; n_flush = 0; abort_at = -1; rel = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    do_cycle();
    rst = 1'b0;
  endtask

  lu_case_t cases[5];

  initial begin
    idle();
    rst = 1'b1;
    m_wait = 0; m_tmr = 0; m_err = 0; m_cnt = 0;
    clr();
    @(posedge clk);
    #1;

    // outputs must stay quiet under reset even with every request asserted
    br = 1; id_mc = 1; ex_wr = 1; ex_src = RD_SRC_MEM; ex_rd = 3; id_rs1 = 3; id_rs1_u = 1;
    do_cycle();
    do_cycle();
    check_eq("rst_cnt", cnt, 0);
    check_eq("rst_err", err, 0);
    idle();
    rst = 0;

    // basic load-use on rs2
    clr();
    ex_rd = 5; ex_wr = 1; ex_src = RD_SRC_MEM; id_rs2 = 5; id_rs2_u = 1;
    do_cycle();
    ex_wr = 0;
    do_cycle();
    idle();
    do_cycle();
    check_eq("lu_stalls", n_stall, 1);
    check_eq("lu_cnt", cnt, 1);
    check_eq("lu_flush", n_flush, 0);

    cases[0] = '{rd:0, wr:1, src:RD_SRC_MEM, rs1:0, rs1u:0, rs2:0, rs2u:1, exp_stalls:0};
    cases[1] = '{rd:5, wr:1, src:RD_SRC_MEM, rs1:0, rs1u:0, rs2:5, rs2u:0, exp_stalls:0};
    cases[2] = '{rd:5, wr:1, src:RD_SRC_ALU, rs1:0, rs1u:0, rs2:5, rs2u:1, exp_stalls:0};
    cases[3] = '{rd:5, wr:0, src:RD_SRC_MEM, rs1:5, rs1u:1, rs2:5, rs2u:1, exp_stalls:0};
    cases[4] = '{rd:7, wr:1, src:RD_SRC_MEM, rs1:7, rs1u:1, rs2:2, rs2u:1, exp_stalls:1};
    for (int i = 0; i < 5; i++) begin
      clr();
      ex_rd = cases[i].rd; ex_wr = cases[i].wr; ex_src = cases[i].src;
      id_rs1 = cases[i].rs1; id_rs1_u = cases[i].rs1u;
      id_rs2 = cases[i].rs2; id_rs2_u = cases[i].rs2u;
      do_cycle();
      idle();
      do_cycle();
      check_eq($sformatf("lu_case%0d", i), n_stall, cases[i].exp_stalls);
    end

    // branch wins over load-use and multi-cycle request
    clr();
    ex_rd = 4; ex_wr = 1; ex_src = RD_SRC_MEM; id_rs1 = 4; id_rs1_u = 1; id_mc = 1; br = 1;
    do_cycle();
    idle();
    check_eq("br_busy", busy, 0);
    check_eq("br_start", n_start, 0);
    check_eq("br_flush", n_flush, 1);

    // multi-cycle op completing after 10 wait cycles
    do_reset();
    clr();
    id_mc = 1;
    for (int k = 0; k <= 10; k++) do_cycle();
    done = 1;
    do_cycle();
    idle();
    do_cycle();
    check_eq("mc_starts", n_start, 1);
    check_eq("mc_stalls", n_stall, 11);
    check_eq("mc_cnt", cnt, 11);
    check_eq("mc_busy_after", busy, 0);

    // multi-cycle op that never completes; counter saturates too
    clr();
    id_mc = 1;
    do_cycle();
    for (int k = 1; k <= 70; k++) begin
      if (n_abort > 0) id_mc = 0;
      do_cycle();
    end
    check_eq("to_aborts", n_abort, 1);
    check_eq("to_abort_cycle", abort_at, 64);
    check_eq("to_err", err, 1);
    check_eq("to_cnt_sat", cnt, CMAX);
    done = 1;
    do_cycle();
    done = 0;
    do_cycle();
    check_eq("to_err_sticky", err, 1);
    check_eq("run_done_busy", busy, 0);

    // reset on the fifth wait cycle
    do_reset();
    check_eq("rst_clears_err", err, 0);
    clr();
    id_mc = 1;
    for (int k = 0; k < 5; k++) do_cycle();
    rst = 1;
    do_cycle();
    rst = 0;
    idle();
    do_cycle();
    check_eq("rstw_abort", n_abort, 0);
    check_eq("rstw_busy", busy, 0);
    check_eq("rstw_err", err, 0);

    // random traffic against the model
    for (int k = 0; k < 300; k++) begin
      id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
      ex_rd = 5'($urandom_range(0, 3));
      id_rs1_u = 1'($urandom); id_rs2_u = 1'($urandom); ex_wr = 1'($urandom);
      ex_src = 2'($urandom_range(0, 2));
      br = ($urandom_range(0, 5) == 0);
      id_mc = ($urandom_range(0, 3) == 0);
      done = ($urandom_range(0, 7) == 0);
      do_cycle();
    end
    idle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

endmodule
